// File: rtl/cursor_move_sequencer.sv
// cursor_move_sequencer: debounced, auto-repeating cursor stepping with grid wrap and recenter
module cursor_move_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int STEP            = 16,
    parameter int X_MAX           = 640,
    parameter int Y_MAX           = 480,
    parameter int X_CENTER        = 320,
    parameter int Y_CENTER        = 240
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  KEY,
    input  logic [9:0]  SW,
    output logic [10:0] x_pos,
    output logic [10:0] y_pos,
    output logic        move_valid
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
    localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES);
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [10:0]   S  = 11'(STEP);
    localparam logic [10:0]   XM = 11'(X_MAX);
    localparam logic [10:0]   YM = 11'(Y_MAX);
    localparam logic [10:0]   XC = 11'(X_CENTER);
    localparam logic [10:0]   YC = 11'(Y_CENTER);

    typedef enum logic [1:0] {IDLE, HOLD_DELAY, HOLD_REPEAT} state_t;

    state_t          state, state_nx;
    logic [3:0]      key_s1, key_s2, db, pressed;
    logic [DW-1:0]   db_cnt [4];
    logic            sw_s1, sw_s2;
    logic [RW-1:0]   rcnt;
    logic [1:0]      owner, owner_nx, pick;
    logic            step, rcnt_clr;
    logic [10:0]     x_nx, y_nx;
    logic            unused_sw;

    assign unused_sw = ^SW[9:1];
    assign pressed   = ~db;
    assign pick      = pressed[3] ? 2'd3 : pressed[2] ? 2'd2 : pressed[1] ? 2'd1 : 2'd0;

    assign y_nx = owner_nx == 2'd3 ? (y_pos >= S ? y_pos - S : y_pos - S + YM)
                : owner_nx == 2'd2 ? (y_pos + S >= YM ? y_pos + S - YM : y_pos + S)
                : y_pos;
    assign x_nx = owner_nx == 2'd1 ? (x_pos >= S ? x_pos - S : x_pos - S + XM)
                : owner_nx == 2'd0 ? (x_pos + S >= XM ? x_pos + S - XM : x_pos + S)
                : x_pos;

    always_comb begin
        state_nx = state;
        owner_nx = owner;
        step     = 1'b0;
        rcnt_clr = 1'b0;
        case (state)
            IDLE: begin
                rcnt_clr = 1'b1;
                if (|pressed) begin
                    step     = 1'b1;
                    owner_nx = pick;
                    state_nx = HOLD_DELAY;
                end
            end
            HOLD_DELAY: begin
                if (!pressed[owner]) begin
                    state_nx = IDLE;
                end else if (rcnt == DELAY_LAST) begin
                    step     = 1'b1;
                    rcnt_clr = 1'b1;
                    state_nx = HOLD_REPEAT;
                end
            end
            HOLD_REPEAT: begin
                if (!pressed[owner]) begin
                    state_nx = IDLE;
                end else if (rcnt == PERIOD_LAST) begin
                    step     = 1'b1;
                    rcnt_clr = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_s1 <= '1;
            key_s2 <= '1;
            sw_s1  <= 1'b0;
            sw_s2  <= 1'b0;
            db     <= '1;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            sw_s1  <= SW[0];
            sw_s2  <= sw_s1;
            for (int i = 0; i < 4; i++) begin
                if (key_s2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= key_s2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        state <= (reset || sw_s2) ? IDLE : state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset || sw_s2) begin
            x_pos      <= XC;
            y_pos      <= YC;
            move_valid <= 1'b0;
            rcnt       <= '0;
            owner      <= 2'd0;
        end else begin
            owner      <= owner_nx;
            move_valid <= step;
            rcnt       <= rcnt_clr ? '0 : rcnt + 1'b1;
            if (step) begin
                x_pos <= x_nx;
                y_pos <= y_nx;
            end
        end
    end
endmodule

// File: tb/tb_cursor_move_sequencer.sv
// tb_cursor_move_sequencer: scoreboard bench with hand-computed step times and positions
module tb_cursor_move_sequencer;
    logic        clk;
    logic        reset;
    logic [3:0]  KEY;
    logic [9:0]  SW;
    logic [10:0] x_pos, y_pos;
    logic        move_valid;

    typedef struct {
        int          c;
        logic [10:0] x;
        logic [10:0] y;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   b;

    cursor_move_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .KEY(KEY),
        .SW(SW),
        .x_pos(x_pos),
        .y_pos(y_pos),
        .move_valid(move_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_step(input int at, input int x, input int y);
        q.push_back('{at, 11'(x), 11'(y)});
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (move_valid === 1'b1) begin
            check("step_expected", int'(q.size() != 0), 1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                check("step_cycle", cyc, e.c);
                check("step_x", int'(x_pos), int'(e.x));
                check("step_y", int'(y_pos), int'(e.y));
            end
        end
    end

    initial begin
        KEY   = 4'hF;
        SW    = '0;
        reset = 1'b1;
        cycles(2);
        check("reset_x", int'(x_pos), 320);
        check("reset_y", int'(y_pos), 240);
        check("reset_mv", int'(move_valid), 0);
        reset = 1'b0;
        cycles(1);
        check("post_reset_x", int'(x_pos), 320);
        check("post_reset_mv", int'(move_valid), 0);

        b = cyc;
        KEY[0] = 1'b0;
        expect_step(b + 8, 336, 240);
        cycles(12);
        KEY[0] = 1'b1;
        cycles(30);

        b = cyc;
        KEY[3] = 1'b0;
        expect_step(b + 8, 336, 224);
        expect_step(b + 28, 336, 208);
        expect_step(b + 36, 336, 192);
        expect_step(b + 44, 336, 176);
        expect_step(b + 52, 336, 160);
        expect_step(b + 60, 336, 144);
        cycles(60);
        KEY[3] = 1'b1;
        cycles(30);
        check("after_repeat_y", int'(y_pos), 144);

        SW[0] = 1'b1;
        cycles(4);
        check("recenter_x", int'(x_pos), 320);
        check("recenter_y", int'(y_pos), 240);
        SW[0] = 1'b0;
        cycles(4);

        b = cyc;
        KEY[1] = 1'b0;
        for (int i = 0; i <= 20; i++)
            expect_step(b + (i == 0 ? 8 : 28 + 8 * (i - 1)), i < 20 ? 320 - 16 * (i + 1) : 624, 240);
        cycles(180);
        KEY[1] = 1'b1;
        cycles(30);
        check("wrap_left_x", int'(x_pos), 624);

        b = cyc;
        KEY[2] = 1'b0;
        for (int i = 0; i <= 14; i++)
            expect_step(b + (i == 0 ? 8 : 28 + 8 * (i - 1)), 624, i < 14 ? 240 + 16 * (i + 1) : 0);
        cycles(132);
        KEY[2] = 1'b1;
        cycles(30);
        check("wrap_down_y", int'(y_pos), 0);

        SW[0] = 1'b1;
        cycles(4);
        SW[0] = 1'b0;
        cycles(4);

        b = cyc;
        KEY[2] = 1'b0;
        KEY[0] = 1'b0;
        expect_step(b + 8, 320, 256);
        cycles(4);
        KEY[1] = 1'b0;
        cycles(11);
        KEY[2] = 1'b1;
        KEY[0] = 1'b1;
        expect_step(b + 24, 304, 256);
        cycles(5);
        check("owner_hold_x", int'(x_pos), 320);
        cycles(6);
        KEY[1] = 1'b1;
        cycles(30);

        b = cyc;
        KEY[3] = 1'b0;
        expect_step(b + 8, 304, 240);
        cycles(12);
        SW[0] = 1'b1;
        cycles(4);
        check("mid_hold_recenter_x", int'(x_pos), 320);
        check("mid_hold_recenter_y", int'(y_pos), 240);
        cycles(24);
        check("recenter_held_x", int'(x_pos), 320);
        KEY[3] = 1'b1;
        cycles(10);
        SW[0] = 1'b0;
        cycles(10);

        KEY[0] = 1'b0;
        cycles(3);
        KEY[0] = 1'b1;
        cycles(20);
        check("glitch_x", int'(x_pos), 320);
        check("glitch_y", int'(y_pos), 240);
        check("steps_outstanding", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cursor_move_sequencer.md
# cursor_move_sequencer

Turns the four active-low push buttons into debounced, auto-repeating cursor step commands and owns the cursor position registers (x_pos, y_pos) read by the video renderer. It debounces the keys, lets one key at a time own the position datapath, applies wrap-around on a 640x480 grid, and recenters on SW[0]. Replaces ad-hoc per-press position updates with a single sequenced write path.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive stable samples needed to accept a key level change (10 ms at 50 MHz).
- REPEAT_DELAY, 25000000: cycles from first step to first auto-repeat step.
- REPEAT_PERIOD, 5000000: cycles between subsequent auto-repeat steps.
- STEP, 16: pixels moved per step.
- X_MAX, 640 / Y_MAX, 480: grid size; legal positions are 0..X_MAX-1 and 0..Y_MAX-1.
- X_CENTER, 320 / Y_CENTER, 240: recenter/reset position.
- clk  in  1  system clock; only clock.
- reset  in  1  synchronous, active-high reset.
- KEY  in  4  raw buttons, active low: [3] up, [2] down, [1] left, [0] right.
- SW  in  10  switches; only SW[0] (recenter, active high) used, others ignored.
- x_pos  out  11  cursor X, registered.
- y_pos  out  11  cursor Y, registered.
- move_valid  out  1  one-cycle pulse on the cycle x_pos/y_pos take a stepped value.

## Operation
- Input sync: each KEY bit and SW[0] pass through 2 flip-flops. SW[0] is not debounced.
- Debounce per key: debounced level (reset value 1 = released) flips when the synchronized sample differs from it for DEBOUNCE_CYCLES consecutive cycles; counter clears whenever sample equals debounced level.
- Pressed = debounced level 0. Priority among simultaneous fresh presses: KEY3 > KEY2 > KEY1 > KEY0.
- FSM states:
  - IDLE: if any key pressed, latch highest-priority key as owner, issue step, go HOLD_DELAY, clear repeat counter.
  - HOLD_DELAY: owner released -> IDLE. Counter reaches REPEAT_DELAY-1 -> step, clear counter, go HOLD_REPEAT.
  - HOLD_REPEAT: owner released -> IDLE. Counter reaches REPEAT_PERIOD-1 -> step, clear counter.
- Non-owner keys are ignored while holding; pressing another key does not preempt. On return to IDLE, any still-pressed key is taken on the next cycle per priority.
- Step arithmetic (11-bit, no overflow possible for legal params):
  - up: y = (y >= STEP) ? y-STEP : y-STEP+Y_MAX; down: y = (y+STEP >= Y_MAX) ? y+STEP-Y_MAX : y+STEP.
  - left/right identical on x with X_MAX. Only the owner axis changes.
- Recenter: while synchronized SW[0]=1, x_pos=X_CENTER, y_pos=Y_CENTER every cycle, FSM forced to IDLE, repeat counter cleared, move_valid=0. Debouncers keep running.
- Priority per cycle: reset > recenter > step.

## Timing
- Reset values: x_pos=X_CENTER, y_pos=Y_CENTER, move_valid=0, FSM IDLE, debounced levels all 1, all counters 0, sync flops 1 (KEY) / 0 (SW).
- KEY pin held low from before edge k: synchronized sample valid at edge k+2, debounced press at edge k+1+DEBOUNCE_CYCLES+1, position update and move_valid at the following edge (total DEBOUNCE_CYCLES+3 edges).
- Second step exactly REPEAT_DELAY cycles after first; then one every REPEAT_PERIOD cycles while held.
- Release: debounced release seen in HOLD_* -> IDLE next edge; no step issued on the releasing cycle.
- move_valid high exactly one cycle per step, coincident with the new position value.
- Reset or SW[0] asserted mid-hold: position recentered on that edge; no pending step emitted.
- Glitch shorter than DEBOUNCE_CYCLES: no debounced change, no step.

## Test plan
Sim params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
- Reset: assert reset 2 cycles -> x_pos=320, y_pos=240, move_valid=0.
- Single tap: KEY0 low 12 cycles then high -> one move_valid pulse 7 edges after fall, x_pos=336, y_pos=240; no further steps.
- Auto-repeat: KEY3 low 60 cycles -> steps at t0, t0+20, t0+28, t0+36, ...; y_pos 240->224->208->192...; stops within 7 cycles of release.
- Wrap: from x=0 press KEY1 once -> x_pos=624; from y=464 press KEY2 once -> y_pos=0.
- Priority/ownership: KEY2 and KEY0 fall same cycle -> only y steps (256); KEY1 pressed later while KEY2 held -> x unchanged until KEY2 released, then KEY1 takes over next cycle.
- Recenter and glitch: during hold set SW[0]=1 -> position 320/240, no move_valid while high; 3-cycle KEY0 pulse -> no step.
